// File: rtl/text_buffer_ctrl.sv
// Character-buffer controller: turns accepted ASCII keys into character-RAM writes
// over a COLS x ROWS buffer with row wrap, top-row-offset scrolling and space fill.
module text_buffer_ctrl #(
    parameter int COLS   = 16,
    parameter int ROWS   = 4,
    parameter int COL_W  = 4,
    parameter int ROW_W  = 2,
    parameter int ADDR_W = 6,
    parameter bit SCROLL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_i,
    input  logic [7:0]        key_code_i,
    output logic              key_ready_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    output logic [ROW_W-1:0]  cursor_row_o,
    output logic [COL_W-1:0]  cursor_col_o,
    output logic [ROW_W-1:0]  top_row_o
);

    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0] COLS_CNT = CNT_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W + 1)'(ROWS);
    localparam logic [7:0]       SPACE    = 8'h20;

    typedef enum logic [1:0] {CLR_ALL, IDLE, WRITE, LINE_CLR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] cursorRow_q, cursorRow_d;
    logic [COL_W-1:0] cursorCol_q, cursorCol_d;
    logic [ROW_W-1:0] topRow_q, topRow_d;
    logic             ramWe_q, ramWe_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [7:0]       ramWdata_q, ramWdata_d;

    logic [ROW_W:0]   rowDiff;
    logic [ROW_W-1:0] logicalRow;
    logic [ROW_W-1:0] advRow, advTop;

    // Row arithmetic is done explicitly mod ROWS so non-power-of-two row counts work.
    function automatic logic [ROW_W-1:0] incRow(input logic [ROW_W-1:0] r);
        return (r == LAST_ROW) ? '0 : r + 1'b1;
    endfunction

    function automatic logic [ROW_W-1:0] decRow(input logic [ROW_W-1:0] r);
        return (r == '0) ? LAST_ROW : r - 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] addrOf(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // Logical row relative to the display top and the row the cursor would move to on advance.
    always_comb begin
        rowDiff = {1'b0, cursorRow_q} + ROWS_EXT - {1'b0, topRow_q};
        if (rowDiff >= ROWS_EXT) begin
            logicalRow = ROW_W'(rowDiff - ROWS_EXT);
        end else begin
            logicalRow = ROW_W'(rowDiff);
        end
        advRow = incRow(cursorRow_q);
        advTop = topRow_q;
        if (logicalRow == LAST_ROW) begin
            advRow = topRow_q;
            if (SCROLL) begin
                advTop = incRow(topRow_q);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cursorRow_d = cursorRow_q;
        cursorCol_d = cursorCol_q;
        topRow_d    = topRow_q;
        ramWe_d     = 1'b0;
        ramAddr_d   = ramAddr_q;
        ramWdata_d  = ramWdata_q;

        case (state_q)
            CLR_ALL: begin
                if (cnt_q < TOTAL) begin
                    ramWe_d    = 1'b1;
                    ramAddr_d  = ADDR_W'(cnt_q);
                    ramWdata_d = SPACE;
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    cursorRow_d = '0;
                    cursorCol_d = '0;
                    topRow_d    = '0;
                end
            end
            IDLE: begin
                if (key_valid_i) begin
                    if (key_code_i >= 8'h20 && key_code_i <= 8'h7E) begin
                        ramWe_d    = 1'b1;
                        ramAddr_d  = addrOf(cursorRow_q, cursorCol_q);
                        ramWdata_d = key_code_i;
                        if (cursorCol_q == LAST_COL) begin
                            cursorCol_d = '0;
                            cursorRow_d = advRow;
                            topRow_d    = advTop;
                            cnt_d       = '0;
                            state_d     = LINE_CLR;
                        end else begin
                            cursorCol_d = cursorCol_q + 1'b1;
                            state_d     = WRITE;
                        end
                    end else if (key_code_i == 8'h08) begin
                        // Backspace never crosses above the displayed top row.
                        if (cursorCol_q != '0) begin
                            cursorCol_d = cursorCol_q - 1'b1;
                            ramWe_d     = 1'b1;
                            ramAddr_d   = addrOf(cursorRow_q, cursorCol_q - 1'b1);
                            ramWdata_d  = SPACE;
                            state_d     = WRITE;
                        end else if (logicalRow != '0) begin
                            cursorRow_d = decRow(cursorRow_q);
                            cursorCol_d = LAST_COL;
                            ramWe_d     = 1'b1;
                            ramAddr_d   = addrOf(decRow(cursorRow_q), LAST_COL);
                            ramWdata_d  = SPACE;
                            state_d     = WRITE;
                        end
                    end else if (key_code_i == 8'h0D) begin
                        // Enter issues the first space of the new line in the same cycle.
                        cursorCol_d = '0;
                        cursorRow_d = advRow;
                        topRow_d    = advTop;
                        ramWe_d     = 1'b1;
                        ramAddr_d   = addrOf(advRow, '0);
                        ramWdata_d  = SPACE;
                        cnt_d       = CNT_W'(1);
                        state_d     = LINE_CLR;
                    end else if (key_code_i == 8'h0C) begin
                        cnt_d   = '0;
                        state_d = CLR_ALL;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            LINE_CLR: begin
                if (cnt_q < COLS_CNT) begin
                    ramWe_d    = 1'b1;
                    ramAddr_d  = addrOf(cursorRow_q, COL_W'(cnt_q));
                    ramWdata_d = SPACE;
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLR_ALL;
            cnt_q       <= '0;
            cursorRow_q <= '0;
            cursorCol_q <= '0;
            topRow_q    <= '0;
            ramWe_q     <= 1'b0;
            ramAddr_q   <= '0;
            ramWdata_q  <= SPACE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cursorRow_q <= cursorRow_d;
            cursorCol_q <= cursorCol_d;
            topRow_q    <= topRow_d;
            ramWe_q     <= ramWe_d;
            ramAddr_q   <= ramAddr_d;
            ramWdata_q  <= ramWdata_d;
        end
    end

    assign key_ready_o  = (state_q == IDLE);
    assign ram_we_o     = ramWe_q;
    assign ram_addr_o   = ramAddr_q;
    assign ram_wdata_o  = ramWdata_q;
    assign cursor_row_o = cursorRow_q;
    assign cursor_col_o = cursorCol_q;
    assign top_row_o    = topRow_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: directed keys push expected RAM writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_text_buffer_ctrl;

    localparam int COLS   = 16;
    localparam int ROWS   = 4;
    localparam int COL_W  = 4;
    localparam int ROW_W  = 2;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              keyValid = 1'b0;
    logic [7:0]        keyCode = 8'h00;

    logic              keyReady, ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [7:0]        ramWdata;
    logic [ROW_W-1:0]  cursorRow, topRow;
    logic [COL_W-1:0]  cursorCol;

    logic              keyReady0, ramWe0;
    logic [ADDR_W-1:0] ramAddr0;
    logic [7:0]        ramWdata0;
    logic [ROW_W-1:0]  cursorRow0, topRow0;
    logic [COL_W-1:0]  cursorCol0;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W+7:0] expQ[$];
    logic [ADDR_W+7:0] expEntry;

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
                       .ADDR_W(ADDR_W), .SCROLL(1'b1)) dut (
        .clk(clk), .reset(reset), .key_valid_i(keyValid), .key_code_i(keyCode),
        .key_ready_o(keyReady), .ram_we_o(ramWe), .ram_addr_o(ramAddr),
        .ram_wdata_o(ramWdata), .cursor_row_o(cursorRow), .cursor_col_o(cursorCol),
        .top_row_o(topRow)
    );

    // Wrap-to-top variant shares stimulus; only its cursor/top after the enter sequence is checked.
    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
                       .ADDR_W(ADDR_W), .SCROLL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .key_valid_i(keyValid), .key_code_i(keyCode),
        .key_ready_o(keyReady0), .ram_we_o(ramWe0), .ram_addr_o(ramAddr0),
        .ram_wdata_o(ramWdata0), .cursor_row_o(cursorRow0), .cursor_col_o(cursorCol0),
        .top_row_o(topRow0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input int addr, input logic [7:0] data);
        expQ.push_back({ADDR_W'(addr), data});
    endtask

    task automatic expectRowClear(input int row);
        for (int c = 0; c < COLS; c++) expectWrite(row * COLS + c, 8'h20);
    endtask

    task automatic expectFullClear();
        for (int a = 0; a < COLS * ROWS; a++) expectWrite(a, 8'h20);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] code);
        int waited = 0;
        while (!keyReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!keyReady) checkOutput("key_ready wait", {31'd0, keyReady}, 32'd1);
        keyValid = 1'b1;
        keyCode  = code;
        @(negedge clk);
        keyValid = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int expCycles);
        int cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!keyReady && cycles < 500);
        checkOutput({name, " ready latency"}, cycles, expCycles);
        checkOutput({name, " pending writes"}, expQ.size(), 0);
    endtask

    task automatic checkCursor(input string name, input int row, input int col, input int top);
        checkOutput({name, " cursor_row"}, 32'(cursorRow), row);
        checkOutput({name, " cursor_col"}, 32'(cursorCol), col);
        checkOutput({name, " top_row"}, 32'(topRow), top);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, " key_ready"}, {31'd0, keyReady}, 0);
        checkOutput({name, " ram_addr"}, 32'(ramAddr), 0);
        checkOutput({name, " ram_wdata"}, 32'(ramWdata), 32'h20);
        checkCursor(name, 0, 0, 0);
    endtask

    function automatic logic [7:0] codeFor(input int i);
        if (i == 1) return 8'h20;
        if (i == 2) return 8'h7E;
        return 8'(8'h41 + i);
    endfunction

    // Monitor: every DUT write must match the next scoreboard entry; no writes while in reset.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("ram_we during reset", {31'd0, ramWe}, 0);
        end else if (ramWe) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected write: addr %0d data 0x%0h, expected no write",
                         ramAddr, ramWdata);
            end else begin
                expEntry = expQ.pop_front();
                checkOutput("ram write addr/data", 32'({ramAddr, ramWdata}), 32'(expEntry));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("in reset");

        expectFullClear();
        #2 reset = 1'b1;
        waitIdle("reset clear", COLS * ROWS + 1);
        checkCursor("after reset clear", 0, 0, 0);

        // First key, then a key offered while busy must be dropped.
        expectWrite(0, 8'h41);
        applyStimulus(8'h41);
        checkOutput("we after A", {31'd0, ramWe}, 1);
        checkOutput("ready low after A", {31'd0, keyReady}, 0);
        checkOutput("col after A", 32'(cursorCol), 1);
        keyValid = 1'b1;
        keyCode  = 8'h42;
        @(negedge clk);
        keyValid = 1'b0;
        checkOutput("ready after WRITE", {31'd0, keyReady}, 1);
        checkOutput("dropped key no write", {31'd0, ramWe}, 0);
        checkOutput("col after dropped", 32'(cursorCol), 1);

        for (int i = 1; i < COLS; i++) begin
            expectWrite(i, codeFor(i));
            if (i == COLS - 1) expectRowClear(1);
            applyStimulus(codeFor(i));
            if (i < COLS - 1) waitIdle("printable", 1);
        end
        waitIdle("row wrap", COLS + 1);
        checkCursor("after row wrap", 1, 0, 0);

        expectWrite(15, 8'h20);
        applyStimulus(8'h08);
        waitIdle("bs row up", 1);
        checkCursor("after bs row up", 0, 15, 0);
        for (int c = 14; c >= 0; c--) begin
            expectWrite(c, 8'h20);
            applyStimulus(8'h08);
            waitIdle("bs", 1);
        end
        applyStimulus(8'h08);
        waitIdle("bs at home", 1);
        checkCursor("after bs at home", 0, 0, 0);

        applyStimulus(8'h07);
        waitIdle("ignored 0x07", 1);
        applyStimulus(8'h7F);
        waitIdle("ignored 0x7F", 1);
        checkCursor("after ignored", 0, 0, 0);

        expectWrite(0, 8'h48);
        applyStimulus(8'h48);
        waitIdle("text H", 1);
        expectWrite(1, 8'h69);
        applyStimulus(8'h69);
        waitIdle("text i", 1);
        checkCursor("before form feed", 0, 2, 0);
        expectFullClear();
        applyStimulus(8'h0C);
        waitIdle("form feed", COLS * ROWS + 1);
        checkCursor("after form feed", 0, 0, 0);

        // Four enters from home: the last one scrolls (or wraps in the SCROLL=0 copy).
        expectRowClear(1);
        applyStimulus(8'h0D);
        waitIdle("enter 1", COLS);
        checkCursor("after enter 1", 1, 0, 0);
        expectRowClear(2);
        applyStimulus(8'h0D);
        waitIdle("enter 2", COLS);
        checkCursor("after enter 2", 2, 0, 0);
        expectRowClear(3);
        applyStimulus(8'h0D);
        waitIdle("enter 3", COLS);
        checkCursor("after enter 3", 3, 0, 0);
        expectRowClear(0);
        applyStimulus(8'h0D);
        waitIdle("enter 4", COLS);
        checkCursor("after enter 4 scroll", 0, 0, 1);
        checkOutput("no-scroll cursor_row", 32'(cursorRow0), 0);
        checkOutput("no-scroll top_row", 32'(topRow0), 0);

        // Physical row 0 is logical row 3 now, so backspace wraps to physical row 3.
        expectWrite(63, 8'h20);
        applyStimulus(8'h08);
        waitIdle("bs wrap rows", 1);
        checkCursor("after bs wrap rows", 3, 15, 1);
        expectWrite(63, 8'h5A);
        expectRowClear(0);
        applyStimulus(8'h5A);
        waitIdle("wrap to row 0", COLS + 1);
        checkCursor("after wrap to row 0", 0, 0, 1);

        expectRowClear(1);
        applyStimulus(8'h0D);
        checkOutput("scroll2 cursor_row", 32'(cursorRow), 1);
        checkOutput("scroll2 top_row", 32'(topRow), 2);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkResetValues("mid line clear reset");
        repeat (2) @(negedge clk);
        expectFullClear();
        #2 reset = 1'b1;
        waitIdle("restart clear", COLS * ROWS + 1);
        checkCursor("after restart clear", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_buffer_ctrl.md
# text_buffer_ctrl

Parametrised character-buffer controller sitting between the PS/2 key-to-ASCII path and the character RAM read by the LCD controller. Consumes one ASCII code per accepted key press; maintains a 2-D cursor over a COLS x ROWS buffer; drives the RAM write port for printable characters, backspace, newline and clear-screen. Adds row wrap, hardware scrolling through a top-row offset, and automatic space-fill of new lines and of the whole buffer.

## Interface
- COLS, 16, characters per row (>=2)
- ROWS, 4, rows in buffer (>=2)
- COL_W, 4, cursor column width; COLS <= 2^COL_W
- ROW_W, 2, cursor row width; ROWS <= 2^ROW_W
- ADDR_W, 6, RAM address width; COLS*ROWS <= 2^ADDR_W
- SCROLL, 1, 1: scroll on overflow of last row; 0: wrap cursor to top row
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle pulse, key_code is a new key press
- key_code  in  8  ASCII code
- key_ready  out  1  controller idle; key accepted when key_valid & key_ready
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM write address = phys_row*COLS + col (registered)
- ram_wdata  out  8  RAM write data (registered)
- cursor_row  out  ROW_W  physical cursor row
- cursor_col  out  COL_W  cursor column
- top_row  out  ROW_W  physical row shown as first display line; display reads (top_row+line) mod ROWS

## Operation
- States: CLR_ALL, IDLE, WRITE, LINE_CLR. key_ready = (state==IDLE). key_valid while not ready is dropped, no buffering, no side effects.
- Logical row L = (cursor_row - top_row) mod ROWS.
- Reset: all outputs 0 except ram_wdata=0x20; state CLR_ALL.
- CLR_ALL: writes 0x20 to addr 0..COLS*ROWS-1, one per cycle, ascending; then cursor=(0,0), top_row=0, IDLE.
- Accepted key decode:
  - 0x20..0x7E printable: WRITE cycle writes code at cursor; then col+1; at col==COLS-1, advance-row instead.
  - 0x08 backspace: col>0: col-1, write 0x20 there. col==0 and L>0: move to (prev physical row mod ROWS, COLS-1), write 0x20. col==0 and L==0: no write, no move, stay IDLE.
  - 0x0D enter: col=0, advance-row.
  - 0x0C form feed: CLR_ALL.
  - anything else: ignored, stay IDLE.
- Advance-row: col=0. L<ROWS-1: cursor_row=(cursor_row+1) mod ROWS. L==ROWS-1, SCROLL=1: top_row=(top_row+1) mod ROWS, cursor_row=old top_row. L==ROWS-1, SCROLL=0: cursor_row=top_row (=0). Always followed by LINE_CLR.
- LINE_CLR: writes 0x20 to new cursor row, col 0..COLS-1 ascending, COLS cycles; cursor_col stays 0; then IDLE.
- Row arithmetic mod ROWS explicitly (ROWS need not be power of 2); address product computed at ADDR_W.

## Timing
- Key accepted at edge N (IDLE, key_valid=1).
- Printable, col<COLS-1: ram_we=1 in cycle N+1 with addr/data of old cursor; cursor_col updated N+1; key_ready=1 at N+2 (max one key per 2 cycles).
- Printable at col COLS-1: char write N+1; cursor/top_row update N+1; LINE_CLR writes N+2..N+COLS+1; ready at N+COLS+2.
- Enter: cursor/top_row update N+1; LINE_CLR N+1..N+COLS; ready at N+COLS+1.
- Backspace: cursor update and space write both in N+1, write at new position; ready at N+2.
- Form feed / reset release: writes on cycles 1..COLS*ROWS after state entry; ready the cycle after the last write.
- ram_we low in every cycle without a write; ram_addr/ram_wdata hold last values.
- reset asserted mid-sequence: outputs immediately return to reset values; full CLR_ALL restarts on release.

## Test plan
- Reset release (defaults) -> 64 consecutive ram_we cycles, addr 0..63, data 0x20; then key_ready=1, cursor (0,0), top_row 0.
- Key 0x41 accepted -> next cycle ram_we=1, addr 0, data 0x41; cursor_col=1; key_valid asserted during that cycle dropped (no second write).
- 16 printable keys on row 0 -> last writes addr 15, then 16 space writes addr 16..31, cursor (1,0); backspace -> space written at addr 15, cursor (0,15); backspace at (0,0) -> no write.
- SCROLL=1: enter x4 from home -> 4th enter gives top_row=1, cursor_row=0, spaces written addr 0..15; SCROLL=0 same sequence -> top_row=0, cursor_row=0.
- Form feed after text -> 64 space writes, cursor (0,0), top_row 0.
- Reset pulsed mid LINE_CLR -> ram_we low during reset, full 64-write clear restarts on release.
